rom_loader: RTL

ROM_LOADER -- requirements
Module: rom_loader

---
 rtl/rom_loader_pkg.sv | 46 ++++
 rtl/rom_region_decode.sv | 35 +++
 rtl/rom_loader.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/rom_loader_pkg.sv
// ---------------------------------------------------------------------------
// rom_loader_pkg
// Shared constants for the ROM loader: the region map (base/size per region,
// all sizes powers of two and bases size-aligned), the expected ROM image
// length, the hps_io download index codes and the loader FSM state type.
// ---------------------------------------------------------------------------
package rom_loader_pkg;

    localparam int RGN_MAX = 6;

    // Region map, contiguous from address 0.
    localparam logic [24:0] RGN_BASE [RGN_MAX] = '{
        25'h000_0000, 25'h000_1000, 25'h000_1800,
        25'h000_1C00, 25'h000_2000, 25'h000_2200
    };
    localparam logic [24:0] RGN_SIZE [RGN_MAX] = '{
        25'h000_1000, 25'h000_0800, 25'h000_0400,
        25'h000_0400, 25'h000_0200, 25'h000_0200
    };

    // Total number of ROM bytes a complete download must deliver.
    localparam logic [17:0] ROM_TOTAL = 18'h0_2400;

    // hps_io download index codes.
    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_CFG = 8'd1;
    localparam logic [7:0] IDX_DIP = 8'd254;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADING = 2'd1,
        DONE    = 2'd2,
        ERROR   = 2'd3
    } state_e;

    // True when addr lies in [base, base+size); 26-bit compare so the end
    // bound cannot wrap.
    function automatic logic in_region(input logic [24:0] addr,
                                       input logic [24:0] base,
                                       input logic [24:0] size);
        logic [25:0] end_addr;
        end_addr  = {1'b0, base} + {1'b0, size};
        in_region = ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < end_addr);
    endfunction

endpackage

// File: rtl/rom_region_decode.sv
// ---------------------------------------------------------------------------
// rom_region_decode
// Combinational region decoder: maps a download address onto a one-hot region
// hit and the region-local address (addr - base, truncated to RGN_AW).
// Ports:
//   addr_i        in  25        download byte address
//   hit_o         out RGN_COUNT one-hot region hit (all zero = no region)
//   local_addr_o  out RGN_AW    address relative to the hit region's base
// ---------------------------------------------------------------------------
module rom_region_decode
    import rom_loader_pkg::*;
#(
    parameter int RGN_COUNT = 6,
    parameter int RGN_AW    = 16
) (
    input  logic [24:0]          addr_i,
    output logic [RGN_COUNT-1:0] hit_o,
    output logic [RGN_AW-1:0]    local_addr_o
);

    // Compare against every region; regions never overlap so at most one hits.
    always_comb begin
        hit_o        = '0;
        local_addr_o = '0;
        for (int k = 0; k < RGN_COUNT; k++) begin
            if (in_region(addr_i, RGN_BASE[k], RGN_SIZE[k])) begin
                hit_o[k]     = 1'b1;
                local_addr_o = RGN_AW'(addr_i - RGN_BASE[k]);
            end else begin
                hit_o[k] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rom_loader.sv
// ---------------------------------------------------------------------------
// rom_loader
// Receives the hps_io download stream and splits the ROM image (index 0) into
// per-region write strobes, latches the core config byte (index 1) and the DIP
// bytes (index 254), and reports load status. The game core is held in reset
// until a complete, in-range image has been delivered.
//
// Optional feature: define ROM_LOADER_CHECKSUM_EN to accumulate a 16-bit
// wrapping sum of all counted ROM bytes on rom_sum; otherwise rom_sum is 0.
//
// Ports:
//   clk_49m         in   system clock (rising edge)
//   reset           in   asynchronous, active-low reset
//   ioctl_download  in   download in progress
//   ioctl_wr        in   byte strobe
//   ioctl_index     in   8   download index
//   ioctl_addr      in   25  byte address
//   ioctl_dout      in   8   byte data
//   rom_wr          out  RGN_COUNT one-hot region write strobe (1 cycle)
//   rom_addr        out  RGN_AW    region-local address
//   rom_data        out  8         write data
//   is_bootleg      out  2, is_japan out 1: config flags
//   dip_sw          out  24  DIP bytes {2,1,0}
//   core_hold       out  high unless a load completed cleanly
//   load_done       out  image complete; load_error out: load failed
//   rom_sum         out  16  ROM byte checksum
// ---------------------------------------------------------------------------
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int RGN_COUNT = 6,
    parameter int RGN_AW    = 16
) (
    input  logic                 clk_49m,
    input  logic                 reset,
    input  logic                 ioctl_download,
    input  logic                 ioctl_wr,
    input  logic [7:0]           ioctl_index,
    input  logic [24:0]          ioctl_addr,
    input  logic [7:0]           ioctl_dout,
    output logic [RGN_COUNT-1:0] rom_wr,
    output logic [RGN_AW-1:0]    rom_addr,
    output logic [7:0]           rom_data,
    output logic [1:0]           is_bootleg,
    output logic                 is_japan,
    output logic [23:0]          dip_sw,
    output logic                 core_hold,
    output logic                 load_done,
    output logic                 load_error,
    output logic [15:0]          rom_sum
);

    state_e                state_q, state_d;
    logic                  dl_q;
    logic [17:0]           cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic [RGN_COUNT-1:0]  rom_wr_q;
    logic [RGN_AW-1:0]     rom_addr_q;
    logic [7:0]            rom_data_q;
    logic [1:0]            bootleg_q;
    logic                  japan_q;
    logic [23:0]           dip_q;

    logic [RGN_COUNT-1:0]  hit_s;
    logic [RGN_AW-1:0]     local_addr_s;
    logic                  fall_s;
    logic                  start_s;
    logic                  rom_byte_s;
    logic                  cfg_wr_s;
    logic                  dip_wr_s;

    rom_region_decode #(
        .RGN_COUNT (RGN_COUNT),
        .RGN_AW    (RGN_AW)
    ) u_decode (
        .addr_i       (ioctl_addr),
        .hit_o        (hit_s),
        .local_addr_o (local_addr_s)
    );

    assign fall_s  = dl_q & ~ioctl_download;
    assign start_s = ioctl_download & (ioctl_index == IDX_ROM);
    // A byte arriving in the same cycle the falling edge is seen still belongs
    // to this load, so it is counted before the terminal check.
    assign rom_byte_s = (state_q == LOADING) & ioctl_wr & (ioctl_index == IDX_ROM)
                      & (ioctl_download | fall_s);
    assign cfg_wr_s = ioctl_wr & (ioctl_index == IDX_CFG) & (ioctl_addr == 25'h0);
    assign dip_wr_s = ioctl_wr & (ioctl_index == IDX_DIP) & (ioctl_addr[24:3] == 22'h0);

    // Byte counter (saturating) and overflow flag; both clear on load entry.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if ((state_q != LOADING) && start_s) begin
            cnt_d = 18'h0;
            ovf_d = 1'b0;
        end else if (rom_byte_s) begin
            cnt_d = (cnt_q == 18'h3_FFFF) ? cnt_q : (cnt_q + 18'd1);
            ovf_d = ovf_q | ~(|hit_s);
        end else begin
            cnt_d = cnt_q;
            ovf_d = ovf_q;
        end
    end

    // Next-state logic; the terminal decision uses the post-update count.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start_s) begin
                    state_d = LOADING;
                end else begin
                    state_d = state_q;
                end
            end
            LOADING: begin
                if (fall_s) begin
                    state_d = ((cnt_d == ROM_TOTAL) && !ovf_d) ? DONE : ERROR;
                end else begin
                    state_d = LOADING;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, download edge detector, counter and overflow registers.
    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            dl_q    <= 1'b0;
            cnt_q   <= 18'h0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dl_q    <= ioctl_download;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Registered region write port: one-cycle strobe, address/data held.
    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            rom_wr_q   <= '0;
            rom_addr_q <= '0;
            rom_data_q <= 8'h00;
        end else begin
            rom_wr_q <= rom_byte_s ? hit_s : '0;
            if (rom_byte_s) begin
                rom_addr_q <= local_addr_s;
                rom_data_q <= ioctl_dout;
            end else begin
                rom_addr_q <= rom_addr_q;
                rom_data_q <= rom_data_q;
            end
        end
    end

    // Config and DIP latches; accepted in any state.
    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            bootleg_q <= 2'b00;
            japan_q   <= 1'b0;
            dip_q     <= 24'h0;
        end else begin
            if (cfg_wr_s) begin
                bootleg_q <= ioctl_dout[1:0];
                japan_q   <= ioctl_dout[4];
            end else begin
                bootleg_q <= bootleg_q;
                japan_q   <= japan_q;
            end
            if (dip_wr_s) begin
                case (ioctl_addr[2:0])
                    3'd0:    dip_q[7:0]   <= ioctl_dout;
                    3'd1:    dip_q[15:8]  <= ioctl_dout;
                    3'd2:    dip_q[23:16] <= ioctl_dout;
                    default: dip_q        <= dip_q;
                endcase
            end else begin
                dip_q <= dip_q;
            end
        end
    end

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;

    // Wrapping sum of counted bytes; cleared on entry, held after the load.
    always_comb begin
        sum_d = sum_q;
        if ((state_q != LOADING) && start_s) begin
            sum_d = 16'h0;
        end else if (rom_byte_s) begin
            sum_d = sum_q + {8'h00, ioctl_dout};
        end else begin
            sum_d = sum_q;
        end
    end

    // Checksum register.
    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            sum_q <= 16'h0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign rom_sum = sum_q;
`else
    assign rom_sum = 16'h0000;
`endif

    assign rom_wr     = rom_wr_q;
    assign rom_addr   = rom_addr_q;
    assign rom_data   = rom_data_q;
    assign is_bootleg = bootleg_q;
    assign is_japan   = japan_q;
    assign dip_sw     = dip_q;
    assign core_hold  = (state_q != DONE);
    assign load_done  = (state_q == DONE);
    assign load_error = (state_q == ERROR);

endmodule
